multi_collision_detect: RTL
===========================

# multi_collision_detect

Parametrised multi-sensor collision detector for the rover drive path. Each of `NUM_SENS` obstacle sensors passes through a 2-flop synchroniser and an independent assert/release debounce FSM. The per-channel results are OR-reduced into a single stop request for the motor controller, with optional latching, a status LED encoding and a saturating collision-event counter.

## Interface
- `NUM_SENS`, 4: number of sensor channels (1..16).
- `CNT_W`, 26: debounce counter width; must hold `max(ASSERT_CYCLES, RELEASE_CYCLES)`.
- `ASSERT_CYCLES`, 50_000: consecutive active synced samples needed to declare a collision (≥1).
- `RELEASE_CYCLES`, 50_000: consecutive inactive synced samples needed to clear a collision (≥1).
- `SENS_ACTIVE_LOW`, 1: 1 = sensor drives 0 on obstacle; 0 = drives 1.
- `LATCH`, 0: 1 = collision holds until `clear`; release counting is disabled.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sens`  in  NUM_SENS  raw asynchronous sensor lines.
- `ch_en`  in  NUM_SENS  per-channel enable; 0 forces the channel to IDLE.
- `clear`  in  1  synchronous pulse: all channels to IDLE, counters and event count to 0.
- `col_detect`  out  1  1 = STOP request (any enabled channel in COLLISION).
- `col_mask`  out  NUM_SENS  per-channel COLLISION flag.
- `led`  out  3  one-hot status: [0] all idle, [1] some channel validating, [2] some channel in collision.
- `col_events`  out  16  saturating count of collision onsets.

## Operation
- Synchroniser: `s1 <= sens`, `s2 <= s1`. Active level `act[i] = SENS_ACTIVE_LOW ? ~s2[i] : s2[i]`.
- Per-channel FSM, states IDLE=0, VALIDATE=1, COLLISION=2. Each channel has a `CNT_W`-bit counter `cnt`.
  - IDLE: if `act`, go to VALIDATE with `cnt=0`.
  - VALIDATE: if `act`, `cnt+1`; when that value equals `ASSERT_CYCLES`, go to COLLISION with `cnt=0`. If `!act`, go to IDLE with `cnt=0`.
  - COLLISION with LATCH=0: if `!act`, `cnt+1`; when that value equals `RELEASE_CYCLES`, go to IDLE with `cnt=0`. If `act`, `cnt=0`.
  - COLLISION with LATCH=1: stay until `clear`; `cnt` held at 0.
  - Encoding 3 is illegal; recover to IDLE with `cnt=0`.
- Priority, highest first: `rst_n`=0, then `clear`, then `ch_en[i]`=0 (forces IDLE, `cnt=0`), then FSM.
- `col_mask[i] = (state[i]==COLLISION)`, decoded from registered state.
- `col_detect = |col_mask`. Disabled channels are already IDLE.
- `led`: [2] if any COLLISION; else [1] if any VALIDATE; else [0]. Always exactly one bit set.
- `col_events`: +1 on any cycle where at least one channel goes VALIDATE→COLLISION. Simultaneous onsets count once. Saturates at 16'hFFFF. Zeroed by reset or `clear`.

## Timing
- Reset values: `s1`, `s2` = inactive level; all states IDLE; all `cnt`=0; `col_detect`=0, `col_mask`=0, `led`=3'b001, `col_events`=0.
- Edge numbering: edge 1 is the first clock edge sampling a new `sens` level.
  - Assert: IDLE→VALIDATE at edge 3. `col_mask` and `col_detect` rise after edge `3+ASSERT_CYCLES`.
  - Release (LATCH=0): `col_mask` falls after edge `2+RELEASE_CYCLES`.
- Any inactive synced sample in VALIDATE aborts the attempt. Any active synced sample in COLLISION restarts the release count.
- `clear` takes effect at the same edge. Outputs read idle values on the next cycle. `clear` wins over a same-cycle onset, so `col_events` ends at 0.
- Deasserting `ch_en[i]` drops `col_mask[i]` after the next edge.
- `rst_n` low mid-count clears all state immediately, without waiting for a clock edge.
- Counters never wrap: compare is exact equality and `cnt` is reset on every transition.

## Test plan
Bench parameters: `NUM_SENS=4`, `ASSERT_CYCLES=4`, `RELEASE_CYCLES=3`, active-low.
- **Assert latency:** `sens[0]` 1→0 held -> `led`=010 after edge 3; `col_mask`=0001, `col_detect`=1 and `led`=100 after edge 7; `col_events`=1.
- **Glitch rejection:** `sens[1]` low for 4 edges then high -> `col_mask[1]` never rises; `led` returns to 001; `col_events` unchanged.
- **Release:** channel 0 in COLLISION, `sens[0]` 0→1 -> `col_mask[0]` falls after edge 5. Repeating with one low sample at edge 4 delays the fall until 3 further consecutive inactive synced samples.
- **Simultaneous and saturation:** `sens[3:2]` fall on the same edge -> both mask bits set after edge 7; `col_events` +1. Force 65 536 onsets -> count holds at FFFF.
- **LATCH=1 and clear:** collision on ch0, then `sens` high for 20 cycles -> `col_mask` stays 0001. Pulse `clear` -> `col_mask`=0, `col_events`=0, `led`=001 next cycle.
- **Enable and reset:** `ch_en[0]`=0 while ch0 is in COLLISION -> `col_detect`=0 next cycle. Assert `rst_n`=0 mid-VALIDATE, between edges -> all outputs at reset values immediately.

Source files
------------

// File: rtl/multi_collision_detect.sv
// Multi-sensor collision detector: per-channel 2-flop sync and assert/release debounce FSM,
// OR-reduced into a stop request with a status LED and a saturating onset counter.
module multi_collision_detect #(
  parameter int unsigned NUM_SENS        = 4,
  parameter int unsigned CNT_W           = 26,
  parameter int unsigned ASSERT_CYCLES   = 50_000,
  parameter int unsigned RELEASE_CYCLES  = 50_000,
  parameter bit          SENS_ACTIVE_LOW = 1'b1,
  parameter bit          LATCH           = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SENS-1:0] sens,
  input  logic [NUM_SENS-1:0] ch_en,
  input  logic                clear,
  output logic                col_detect,
  output logic [NUM_SENS-1:0] col_mask,
  output logic [2:0]          led,
  output logic [15:0]         col_events
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StValidate  = 2'd1,
    StCollision = 2'd2
  } state_e;

  localparam logic [NUM_SENS-1:0] InactLvl   = SENS_ACTIVE_LOW ? {NUM_SENS{1'b1}} : '0;
  localparam logic [CNT_W-1:0]    AssertCnt  = CNT_W'(ASSERT_CYCLES);
  localparam logic [CNT_W-1:0]    ReleaseCnt = CNT_W'(RELEASE_CYCLES);

  logic [NUM_SENS-1:0] s1_q, s2_q, act;
  state_e              state_q [NUM_SENS];
  state_e              state_d [NUM_SENS];
  logic [CNT_W-1:0]    cnt_q   [NUM_SENS];
  logic [CNT_W-1:0]    cnt_d   [NUM_SENS];
  logic [15:0]         events_q, events_d;
  logic                onset;
  logic                any_val;

  assign act = SENS_ACTIVE_LOW ? ~s2_q : s2_q;

  always_comb begin
    onset = 1'b0;
    for (int unsigned i = 0; i < NUM_SENS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (clear || !ch_en[i]) begin
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          StIdle: begin
            if (act[i]) begin
              state_d[i] = StValidate;
              cnt_d[i]   = '0;
            end
          end
          StValidate: begin
            if (!act[i]) begin
              state_d[i] = StIdle;
              cnt_d[i]   = '0;
            end else if ((cnt_q[i] + CNT_W'(1)) == AssertCnt) begin
              state_d[i] = StCollision;
              cnt_d[i]   = '0;
              onset      = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          StCollision: begin
            // Latched collisions never count toward release; only clear/disable/reset exit.
            if (LATCH || act[i]) begin
              cnt_d[i] = '0;
            end else if ((cnt_q[i] + CNT_W'(1)) == ReleaseCnt) begin
              state_d[i] = StIdle;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end

    events_d = events_q;
    if (clear) begin
      events_d = '0;
    end else if (onset && (events_q != 16'hFFFF)) begin
      events_d = events_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= InactLvl;
      s2_q     <= InactLvl;
      events_q <= '0;
      for (int unsigned i = 0; i < NUM_SENS; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q     <= sens;
      s2_q     <= s1_q;
      events_q <= events_d;
      for (int unsigned i = 0; i < NUM_SENS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    col_mask = '0;
    any_val  = 1'b0;
    for (int unsigned i = 0; i < NUM_SENS; i++) begin
      col_mask[i] = (state_q[i] == StCollision);
      if (state_q[i] == StValidate) any_val = 1'b1;
    end
    if (|col_mask) begin
      led = 3'b100;
    end else if (any_val) begin
      led = 3'b010;
    end else begin
      led = 3'b001;
    end
  end

  assign col_detect = |col_mask;
  assign col_events = events_q;

endmodule
